// File: rtl/fifo_sync_n.sv
// Single-clock show-ahead FIFO with power-of-two depth, fill level, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_sync_n #(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned DEPTH_LOG2   = 3,
   parameter int unsigned AFULL_LEVEL  = 6,
   parameter int unsigned AEMPTY_LEVEL = 2
) (
   input  logic                  clk,
   input  logic                  reset_p,
   input  logic [WIDTH-1:0]      data_i,
   input  logic                  data_we,
   output logic [WIDTH-1:0]      data_o,
   input  logic                  data_rd,
   output logic                  full,
   output logic                  empty,
   output logic                  afull,
   output logic                  aempty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] AFULL_THR  = (DEPTH_LOG2+1)'(AFULL_LEVEL);
   localparam logic [DEPTH_LOG2:0] AEMPTY_THR = (DEPTH_LOG2+1)'(AEMPTY_LEVEL);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2:0]   wr_ptr;
   logic [DEPTH_LOG2:0]   rd_ptr;
   logic                  wr_en;
   logic                  rd_en;

   // Extra pointer MSB distinguishes full from empty when addresses coincide.
   always_comb begin
      full   = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
               (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
      empty  = (wr_ptr == rd_ptr);
      level  = wr_ptr - rd_ptr;
      afull  = (level >= AFULL_THR);
      aempty = (level <= AEMPTY_THR);
      wr_en  = data_we & ~full;
      rd_en  = data_rd & ~empty;
      data_o = mem[rd_ptr[DEPTH_LOG2-1:0]];
   end

   always_ff @(posedge clk) begin
      if (wr_en && !reset_p) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // A new error event takes priority over a coincident clear.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (data_we && full) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
         if (data_rd && empty) begin
            underflow <= 1'b1;
         end else if (err_clr) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_sync_n.sv
// Bench for fifo_sync_n: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a queue-based model.
module tb_fifo_sync_n;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DL2   = 3;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AFL   = 6;
   localparam int unsigned AEL   = 2;

   logic             clk = 1'b0;
   logic             reset_p = 1'b0;
   logic [WIDTH-1:0] data_i = '0;
   logic             data_we = 1'b0;
   logic [WIDTH-1:0] data_o;
   logic             data_rd = 1'b0;
   logic             full, empty, afull, aempty;
   logic [DL2:0]     level;
   logic             overflow, underflow;
   logic             err_clr = 1'b0;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic        cmp_en  = 1'b0;

   logic [WIDTH-1:0] q[$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;

   fifo_sync_n #(
      .WIDTH(WIDTH),
      .DEPTH_LOG2(DL2),
      .AFULL_LEVEL(AFL),
      .AEMPTY_LEVEL(AEL)
   ) dut (
      .clk(clk),
      .reset_p(reset_p),
      .data_i(data_i),
      .data_we(data_we),
      .data_o(data_o),
      .data_rd(data_rd),
      .full(full),
      .empty(empty),
      .afull(afull),
      .aempty(aempty),
      .level(level),
      .overflow(overflow),
      .underflow(underflow),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: flags judged on the occupancy before the edge.
   always @(posedge clk) begin
      if (reset_p) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         automatic bit was_full  = (q.size() == DEPTH);
         automatic bit was_empty = (q.size() == 0);
         if (data_rd && !was_empty) void'(q.pop_front());
         if (data_we && !was_full)  q.push_back(data_i);
         if (data_we && was_full) m_ovf = 1'b1;
         else if (err_clr)        m_ovf = 1'b0;
         if (data_rd && was_empty) m_unf = 1'b1;
         else if (err_clr)         m_unf = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("level",     32'(level),     32'(q.size()));
         check("full",      32'(full),      32'(q.size() == DEPTH));
         check("empty",     32'(empty),     32'(q.size() == 0));
         check("afull",     32'(afull),     32'(q.size() >= AFL));
         check("aempty",    32'(aempty),    32'(q.size() <= AEL));
         check("overflow",  32'(overflow),  32'(m_ovf));
         check("underflow", 32'(underflow), 32'(m_unf));
         if (q.size() != 0) check("data_o", 32'(data_o), 32'(q[0]));
      end
   end

   task automatic cyc(input logic we, input logic rd, input logic clr,
                      input logic rst, input logic [WIDTH-1:0] d);
      data_we = we;
      data_rd = rd;
      err_clr = clr;
      reset_p = rst;
      data_i  = d;
      @(posedge clk);
      #1;
      data_we = 1'b0;
      data_rd = 1'b0;
      err_clr = 1'b0;
      reset_p = 1'b0;
   endtask

   initial begin
      // Reset with a write attempt that must be discarded
      cyc(1, 0, 0, 1, 16'h1234);
      cmp_en = 1'b1;
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_level", 32'(level), 0);
      check("rst_aempty", 32'(aempty), 1);
      check("rst_afull", 32'(afull), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_unf", 32'(underflow), 0);

      // Fill with threshold tracking, then overflow
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 0, 0, 0, 16'(i));
         check("fill_level", 32'(level), 32'(i));
         check("fill_aempty", 32'(aempty), 32'(i <= 2));
         check("fill_afull", 32'(afull), 32'(i >= 6));
      end
      check("fill_full", 32'(full), 1);
      cyc(1, 0, 0, 0, 16'hDEAD);
      check("ovf_set", 32'(overflow), 1);
      check("ovf_level", 32'(level), 8);

      // Drain in order, then underflow and clear
      for (int i = 1; i <= 8; i++) begin
         check("drain_data", 32'(data_o), 32'(i));
         cyc(0, 1, 0, 0, '0);
         check("drain_afull", 32'(afull), 32'((8 - i) >= 6));
      end
      check("drain_empty", 32'(empty), 1);
      cyc(0, 1, 0, 0, '0);
      check("unf_set", 32'(underflow), 1);
      cyc(0, 0, 1, 0, '0);
      check("clr_ovf", 32'(overflow), 0);
      check("clr_unf", 32'(underflow), 0);

      // Wrap-around, repeated so the pointer MSB wraps
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 16'h0050 + 16'(i));
         for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, '0);
         for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 16'h0100 + 16'(i));
         for (int i = 0; i < 8; i++) begin
            check("wrap_data", 32'(data_o), 32'h100 + 32'(i));
            cyc(0, 1, 0, 0, '0);
         end
         check("wrap_level", 32'(level), 0);
      end

      // Simultaneous read/write at level 4
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 16'h0A00 + 16'(i));
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 16'h0B00 + 16'(i));
      check("simul_level", 32'(level), 4);
      check("simul_head", 32'(data_o), 32'h0B06);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, '0);

      // Both at empty: write taken, read rejected
      cyc(1, 1, 0, 0, 16'h0C00);
      check("empty_both_level", 32'(level), 1);
      check("empty_both_unf", 32'(underflow), 1);
      cyc(0, 0, 1, 0, '0);
      for (int i = 1; i < 8; i++) cyc(1, 0, 0, 0, 16'h0C00 + 16'(i));
      // Both at full: read taken, write rejected
      cyc(1, 1, 0, 0, 16'hFFFF);
      check("full_both_level", 32'(level), 7);
      check("full_both_ovf", 32'(overflow), 1);
      check("full_both_head", 32'(data_o), 32'h0C01);

      // Reset mid-stream at level 5
      cyc(0, 0, 1, 0, '0);
      while (level > 5) cyc(0, 1, 0, 0, '0);
      cyc(1, 1, 0, 1, 16'h5555);
      check("mid_rst_level", 32'(level), 0);
      check("mid_rst_empty", 32'(empty), 1);
      cyc(1, 0, 0, 0, 16'hBEEF);
      check("beef_data", 32'(data_o), 32'hBEEF);
      check("beef_empty", 32'(empty), 0);

      // Randomized traffic with occasional error clears and resets
      for (int i = 0; i < 3000; i++) begin
         automatic int unsigned bias = (i / 500) % 3;
         automatic logic we  = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
         automatic logic rd  = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
         automatic logic clr = ($urandom_range(0, 19) == 0);
         automatic logic rst = ($urandom_range(0, 299) == 0);
         cyc(we, rd, clr, rst, 16'($urandom));
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_sync_n.md
# fifo_sync_n

Parametrised single-clock FIFO with show-ahead (first-word-fall-through) output. It generalises the fixed 8-deep FIFO to any power-of-two depth and adds:
- fill level output
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags

It sits between producer and consumer stages in the same clock domain.

## Interface
- WIDTH, 16, data word width in bits (1..256)
- DEPTH_LOG2, 3, log2 of depth; DEPTH = 2**DEPTH_LOG2 (1..10)
- AFULL_LEVEL, 6, afull asserts when level >= AFULL_LEVEL (1..DEPTH)
- AEMPTY_LEVEL, 2, aempty asserts when level <= AEMPTY_LEVEL (0..DEPTH-1)

- clk  in  1  clock; all logic on rising edge
- reset_p  in  1  synchronous, active-high reset (1 = reset)
- data_i  in  WIDTH  write data
- data_we  in  1  write request
- data_o  out  WIDTH  oldest stored word (show-ahead)
- data_rd  in  1  read request; pops the word currently on data_o
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- afull  out  1  level >= AFULL_LEVEL
- aempty  out  1  level <= AEMPTY_LEVEL
- level  out  DEPTH_LOG2+1  number of stored words, 0..DEPTH
- overflow  out  1  sticky: write requested while full
- underflow  out  1  sticky: read requested while empty
- err_clr  in  1  clears overflow/underflow

## Operation
- **Storage:** DEPTH x WIDTH array; contents are not reset.
- **Pointers:** wr_ptr and rd_ptr are DEPTH_LOG2+1 bits each and wrap modulo 2*DEPTH.
  - Address is the low DEPTH_LOG2 bits.
  - level = wr_ptr - rd_ptr, computed modulo 2**(DEPTH_LOG2+1).
  - full: address bits equal and MSBs differ.
  - empty: pointers equal.
- **Write accept:** data_we & ~full. Stores data_i at wr_ptr and increments wr_ptr.
- **Read accept:** data_rd & ~empty. Increments rd_ptr.
- **Flag basis:** full and empty are the registered state at the start of the cycle.
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- **Simultaneous accepted write and read:** level unchanged. Data order is preserved across pointer wrap.
- **Error flags:**
  - overflow sets on data_we & full.
  - underflow sets on data_rd & empty.
  - Both hold until err_clr or reset.
  - If err_clr coincides with a new error event, set wins.
- **Status outputs:** full, empty, afull, aempty and level are derived from the pointer registers only, never from the current-cycle inputs.
- **data_o:** equals mem[rd_ptr] whenever empty = 0. Its value is don't-care while empty = 1.

## Timing
- **Reset:**
  - reset_p sampled high at an edge forces wr_ptr = rd_ptr = 0 and overflow = underflow = 0.
  - Reset overrides any data_we, data_rd or err_clr in that cycle; a write in the reset cycle is discarded.
  - After the reset edge: empty = 1, full = 0, level = 0, aempty = 1, afull = 0, overflow = 0, underflow = 0.
  - Reset mid-operation discards all stored words; the same values apply.
- **Status latency:** an accepted write or read updates level, full, empty, afull and aempty one cycle after the accepting edge. There is no combinational path from data_we or data_rd to any status output.
- **Write-to-read latency:** after a write into an empty FIFO, empty falls and data_o presents the word one cycle later. Minimum write-to-read turnaround is 1 cycle.
- **Read advance:** after an accepted read, data_o shows the next word in the following cycle.
- **Throughput:** one write and one read per cycle sustained, provided the FIFO is neither full nor empty.
- **Error flag latency:** overflow and underflow assert one cycle after the offending edge.

## Test plan
1. **Reset defaults:** reset_p = 1 for one cycle with data_we = 1, data_i = 0x1234 -> empty = 1, full = 0, level = 0, aempty = 1, afull = 0, overflow = underflow = 0; write discarded.
2. **Fill, overflow, drain (DEPTH_LOG2 = 3):**
   - Write 0x0001..0x0008 -> full = 1 and level = 8 one cycle after the 8th write.
   - 9th write 0xDEAD -> rejected, overflow = 1.
   - Read 8 -> data_o gives 0x0001..0x0008 in order, then empty = 1.
   - Extra read -> underflow = 1.
   - err_clr -> both flags 0.
3. **Wrap-around:** write 5 / read 5, then write 0x0100..0x0107 / read 8 -> exact order 0x0100..0x0107, level returns to 0; repeat 3 times for pointer MSB wrap.
4. **Simultaneous accesses:**
   - At level 4, data_we = data_rd = 1 for 10 cycles -> level stays 4 and output order is preserved.
   - At level 0, both asserted -> write accepted, read rejected, underflow = 1, level = 1.
   - At level 8, both asserted -> read accepted, write rejected, overflow = 1, level = 7.
5. **Thresholds (AFULL_LEVEL = 6, AEMPTY_LEVEL = 2):**
   - aempty stays 1 through the 2nd write and falls one cycle after the 3rd write.
   - afull rises one cycle after the 6th write and falls one cycle after the read that brings level to 5.
6. **Reset mid-stream:** at level 5, reset_p with data_we = data_rd = 1 -> next cycle level = 0, empty = 1; a subsequent write of 0xBEEF appears on data_o one cycle later.
